// File: rtl/qrcode_cluster_if.sv
// Hit-record input and box-record output bundle for qrcode_cluster.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface qrcode_cluster_if;
   logic       iFRAME_START;
   logic       iFRAME_END;
   logic       iHIT_VALID;
   logic [9:0] iHIT_VCNT;
   logic [9:0] iHIT_HSTART;
   logic [9:0] iHIT_HEND;
   logic       oHIT_READY;
   logic       oBOX_VALID;
   logic       iBOX_READY;
   logic [9:0] oBOX_HST;
   logic [9:0] oBOX_HED;
   logic [9:0] oBOX_VST;
   logic [9:0] oBOX_VED;
   logic [5:0] oBOX_LINES;
   logic       oDONE;
   logic [2:0] oBOX_COUNT;
   logic [7:0] oDROP_COUNT;

   modport slave (
      input  iFRAME_START, iFRAME_END, iHIT_VALID, iHIT_VCNT, iHIT_HSTART, iHIT_HEND,
             iBOX_READY,
      output oHIT_READY, oBOX_VALID, oBOX_HST, oBOX_HED, oBOX_VST, oBOX_VED,
             oBOX_LINES, oDONE, oBOX_COUNT, oDROP_COUNT
   );

   modport master (
      output iFRAME_START, iFRAME_END, iHIT_VALID, iHIT_VCNT, iHIT_HSTART, iHIT_HEND,
             iBOX_READY,
      input  oHIT_READY, oBOX_VALID, oBOX_HST, oBOX_HED, oBOX_VST, oBOX_VED,
             oBOX_LINES, oDONE, oBOX_COUNT, oDROP_COUNT
   );
endinterface

// File: rtl/qrcode_cluster.sv
// Groups finder-pattern line hits into bounding boxes per frame and streams the
// qualified boxes out after frame end.
module qrcode_cluster #(
   parameter int unsigned pSLOTS     = 3,
   parameter int unsigned pHTOL      = 4,
   parameter int unsigned pVGAP      = 2,
   parameter int unsigned pMIN_LINES = 3
) (
   input  logic            iCLK,
   input  logic            iRESET,
   qrcode_cluster_if.slave io_bus
);
   localparam int unsigned      lpIW   = (pSLOTS > 1) ? $clog2(pSLOTS) : 1;
   localparam logic signed [10:0] lpHTOL = 11'(pHTOL);
   localparam logic signed [10:0] lpVWIN = 11'(pVGAP + 1);
   localparam logic [5:0]        lpMIN  = 6'(pMIN_LINES);
   localparam logic [lpIW-1:0]   lpLAST = lpIW'(pSLOTS - 1);

   typedef enum logic [1:0] {sIDLE, sCOLLECT, sFLUSH} state_t;
   typedef enum logic [1:0] {SL_FREE, SL_OPEN, SL_KEPT} slot_t;

   state_t r_state;
   state_t w_state_nxt;

   slot_t      r_slot_st [pSLOTS];
   logic [9:0] r_hst     [pSLOTS];
   logic [9:0] r_hed     [pSLOTS];
   logic [9:0] r_vst     [pSLOTS];
   logic [9:0] r_ved     [pSLOTS];
   logic [5:0] r_lines   [pSLOTS];

   logic signed [10:0] w_dv  [pSLOTS];
   logic signed [10:0] w_dhs [pSLOTS];
   logic signed [10:0] w_dhe [pSLOTS];
   logic [pSLOTS-1:0]  w_aged;
   logic [pSLOTS-1:0]  w_match;
   logic [pSLOTS-1:0]  w_free;
   logic               w_match_hit;
   logic [lpIW-1:0]    w_match_idx;
   logic               w_alloc_hit;
   logic [lpIW-1:0]    w_alloc_idx;
   logic               w_hit_acc;

   logic            r_hit_ready;
   logic            r_box_valid;
   logic [9:0]      r_box_hst;
   logic [9:0]      r_box_hed;
   logic [9:0]      r_box_vst;
   logic [9:0]      r_box_ved;
   logic [5:0]      r_box_lines;
   logic            r_done;
   logic [2:0]      r_box_cnt;
   logic [7:0]      r_drop;
   logic [lpIW-1:0] r_scan;

   logic w_slot_qual;
   logic w_scan_adv;
   logic w_box_load;

   assign w_hit_acc = io_bus.iHIT_VALID && r_hit_ready && !io_bus.iFRAME_START;

   // Ageing and matching both see the pre-hit slot contents; a slot freed by
   // ageing is visible to allocation in the same cycle through w_free.
   always_comb begin
      w_aged      = '0;
      w_match     = '0;
      w_free      = '0;
      w_match_hit = 1'b0;
      w_match_idx = '0;
      w_alloc_hit = 1'b0;
      w_alloc_idx = '0;
      for (int unsigned i = 0; i < pSLOTS; i++) begin
         w_dv[i]  = $signed({1'b0, io_bus.iHIT_VCNT})   - $signed({1'b0, r_ved[i]});
         w_dhs[i] = $signed({1'b0, io_bus.iHIT_HSTART}) - $signed({1'b0, r_hst[i]});
         w_dhe[i] = $signed({1'b0, io_bus.iHIT_HEND})   - $signed({1'b0, r_hed[i]});
         w_aged[i]  = (r_slot_st[i] == SL_OPEN) && (w_dv[i] > lpVWIN);
         w_match[i] = (r_slot_st[i] == SL_OPEN) &&
                      (w_dv[i] >= 11'sd1) && (w_dv[i] <= lpVWIN) &&
                      (w_dhs[i] >= -lpHTOL) && (w_dhs[i] <= lpHTOL) &&
                      (w_dhe[i] >= -lpHTOL) && (w_dhe[i] <= lpHTOL);
         w_free[i]  = (r_slot_st[i] == SL_FREE) || (w_aged[i] && (r_lines[i] < lpMIN));
      end
      for (int unsigned i = 0; i < pSLOTS; i++) begin
         if (w_match[i] && !w_match_hit) begin
            w_match_hit = 1'b1;
            w_match_idx = lpIW'(i);
         end
         if (w_free[i] && !w_alloc_hit) begin
            w_alloc_hit = 1'b1;
            w_alloc_idx = lpIW'(i);
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         for (int unsigned i = 0; i < pSLOTS; i++) begin
            r_slot_st[i] <= SL_FREE;
            r_hst[i]     <= '0;
            r_hed[i]     <= '0;
            r_vst[i]     <= '0;
            r_ved[i]     <= '0;
            r_lines[i]   <= '0;
         end
      end else if (io_bus.iFRAME_START) begin
         for (int unsigned i = 0; i < pSLOTS; i++) begin
            r_slot_st[i] <= SL_FREE;
         end
      end else if (w_hit_acc) begin
         for (int unsigned i = 0; i < pSLOTS; i++) begin
            if (w_aged[i]) begin
               r_slot_st[i] <= (r_lines[i] >= lpMIN) ? SL_KEPT : SL_FREE;
            end
         end
         if (w_match_hit) begin
            if (io_bus.iHIT_HSTART < r_hst[w_match_idx]) r_hst[w_match_idx] <= io_bus.iHIT_HSTART;
            if (io_bus.iHIT_HEND > r_hed[w_match_idx])   r_hed[w_match_idx] <= io_bus.iHIT_HEND;
            r_ved[w_match_idx]   <= io_bus.iHIT_VCNT;
            r_lines[w_match_idx] <= (r_lines[w_match_idx] == 6'd63) ? 6'd63
                                                                     : r_lines[w_match_idx] + 6'd1;
         end else if (w_alloc_hit) begin
            r_slot_st[w_alloc_idx] <= SL_OPEN;
            r_hst[w_alloc_idx]     <= io_bus.iHIT_HSTART;
            r_hed[w_alloc_idx]     <= io_bus.iHIT_HEND;
            r_vst[w_alloc_idx]     <= io_bus.iHIT_VCNT;
            r_ved[w_alloc_idx]     <= io_bus.iHIT_VCNT;
            r_lines[w_alloc_idx]   <= 6'd1;
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         r_drop <= '0;
      end else if (io_bus.iFRAME_START) begin
         r_drop <= '0;
      end else if (w_hit_acc && !w_match_hit && !w_alloc_hit && (r_drop != 8'hFF)) begin
         r_drop <= r_drop + 8'd1;
      end
   end

   assign w_slot_qual = (r_slot_st[r_scan] != SL_FREE) && (r_lines[r_scan] >= lpMIN);
   assign w_scan_adv  = (r_state == sFLUSH) && !io_bus.iFRAME_START &&
                        ((r_box_valid && io_bus.iBOX_READY) || (!r_box_valid && !w_slot_qual));
   assign w_box_load  = (r_state == sFLUSH) && !io_bus.iFRAME_START &&
                        !r_box_valid && w_slot_qual;

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) r_state <= sIDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (io_bus.iFRAME_START) begin
         w_state_nxt = sCOLLECT;
      end else begin
         case (r_state)
            sCOLLECT: if (io_bus.iFRAME_END) w_state_nxt = sFLUSH;
            sFLUSH:   if (w_scan_adv && (r_scan == lpLAST)) w_state_nxt = sIDLE;
            default:  w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         r_hit_ready <= 1'b0;
         r_box_valid <= 1'b0;
         r_box_hst   <= '0;
         r_box_hed   <= '0;
         r_box_vst   <= '0;
         r_box_ved   <= '0;
         r_box_lines <= '0;
         r_done      <= 1'b0;
         r_box_cnt   <= '0;
         r_scan      <= '0;
      end else begin
         r_hit_ready <= (w_state_nxt == sCOLLECT);
         r_done      <= w_scan_adv && (r_scan == lpLAST);
         if (io_bus.iFRAME_START) begin
            r_box_valid <= 1'b0;
            r_box_cnt   <= '0;
            r_scan      <= '0;
         end else begin
            if ((r_state == sCOLLECT) && io_bus.iFRAME_END) r_scan <= '0;
            if (w_box_load) begin
               r_box_valid <= 1'b1;
               r_box_hst   <= r_hst[r_scan];
               r_box_hed   <= r_hed[r_scan];
               r_box_vst   <= r_vst[r_scan];
               r_box_ved   <= r_ved[r_scan];
               r_box_lines <= r_lines[r_scan];
            end
            if ((r_state == sFLUSH) && r_box_valid && io_bus.iBOX_READY) begin
               r_box_valid <= 1'b0;
               r_box_cnt   <= r_box_cnt + 3'd1;
            end
            if (w_scan_adv && (r_scan != lpLAST)) r_scan <= r_scan + 1'b1;
         end
      end
   end

   assign io_bus.oHIT_READY  = r_hit_ready;
   assign io_bus.oBOX_VALID  = r_box_valid;
   assign io_bus.oBOX_HST    = r_box_hst;
   assign io_bus.oBOX_HED    = r_box_hed;
   assign io_bus.oBOX_VST    = r_box_vst;
   assign io_bus.oBOX_VED    = r_box_ved;
   assign io_bus.oBOX_LINES  = r_box_lines;
   assign io_bus.oDONE       = r_done;
   assign io_bus.oBOX_COUNT  = r_box_cnt;
   assign io_bus.oDROP_COUNT = r_drop;
endmodule

// File: tb/tb_qrcode_cluster.sv
// Directed bench for qrcode_cluster with hand-computed box expectations.
module tb_qrcode_cluster;
   logic iCLK;
   logic iRESET;
   int   n_checks;
   int   n_fail;
   int   nbox;
   int   done_cnt;
   bit   got_done;
   int   bx_hst [4];
   int   bx_hed [4];
   int   bx_vst [4];
   int   bx_ved [4];
   int   bx_lin [4];

   qrcode_cluster_if bus ();

   qrcode_cluster #(
      .pSLOTS(3), .pHTOL(4), .pVGAP(2), .pMIN_LINES(3)
   ) u_dut (
      .iCLK   (iCLK),
      .iRESET (iRESET),
      .io_bus (bus)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic frame_start();
      bus.iFRAME_START = 1'b1;
      tick();
      bus.iFRAME_START = 1'b0;
   endtask

   task automatic send_hit(input int v, input int hs, input int he);
      bus.iHIT_VALID  = 1'b1;
      bus.iHIT_VCNT   = 10'(v);
      bus.iHIT_HSTART = 10'(hs);
      bus.iHIT_HEND   = 10'(he);
      tick();
      bus.iHIT_VALID  = 1'b0;
   endtask

   // Pulses frame end, then collects boxes; each box is held off 'stall' cycles.
   task automatic run_flush(input int stall);
      nbox     = 0;
      done_cnt = -1;
      got_done = 1'b0;
      bus.iBOX_READY = (stall == 0);
      bus.iFRAME_END = 1'b1;
      tick();
      bus.iFRAME_END = 1'b0;
      for (int c = 0; c < 200 && !got_done; c++) begin
         if (bus.oDONE) begin
            got_done = 1'b1;
            done_cnt = int'(bus.oBOX_COUNT);
         end else if (bus.oBOX_VALID) begin
            if (nbox < 4) begin
               bx_hst[nbox] = int'(bus.oBOX_HST);
               bx_hed[nbox] = int'(bus.oBOX_HED);
               bx_vst[nbox] = int'(bus.oBOX_VST);
               bx_ved[nbox] = int'(bus.oBOX_VED);
               bx_lin[nbox] = int'(bus.oBOX_LINES);
            end
            for (int s = 0; s < stall; s++) begin
               tick();
               check("hold_valid", 32'(bus.oBOX_VALID), 32'd1);
               check("hold_hst",   32'(bus.oBOX_HST),   32'(bx_hst[nbox]));
               check("hold_ved",   32'(bus.oBOX_VED),   32'(bx_ved[nbox]));
            end
            nbox++;
            bus.iBOX_READY = 1'b1;
            tick();
            bus.iBOX_READY = (stall == 0);
         end else begin
            tick();
         end
      end
      check("done_seen", 32'(got_done), 32'd1);
      bus.iBOX_READY = 1'b0;
   endtask

   task automatic expect_box(input string tag, input int k,
                             input int hst, input int hed, input int vst, input int ved,
                             input int lin);
      check({tag, "_hst"},   32'(bx_hst[k]), 32'(hst));
      check({tag, "_hed"},   32'(bx_hed[k]), 32'(hed));
      check({tag, "_vst"},   32'(bx_vst[k]), 32'(vst));
      check({tag, "_ved"},   32'(bx_ved[k]), 32'(ved));
      check({tag, "_lines"}, 32'(bx_lin[k]), 32'(lin));
   endtask

   task automatic wait_valid(input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (bus.oBOX_VALID) seen = 1'b1;
         else tick();
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      bit done_any;
      n_checks = 0;
      n_fail   = 0;
      iRESET = 1'b0;
      bus.iFRAME_START = 1'b0;
      bus.iFRAME_END   = 1'b0;
      bus.iHIT_VALID   = 1'b0;
      bus.iHIT_VCNT    = '0;
      bus.iHIT_HSTART  = '0;
      bus.iHIT_HEND    = '0;
      bus.iBOX_READY   = 1'b0;
      repeat (3) tick();
      check("rst_hit_ready", 32'(bus.oHIT_READY),  32'd0);
      check("rst_box_valid", 32'(bus.oBOX_VALID),  32'd0);
      check("rst_done",      32'(bus.oDONE),       32'd0);
      check("rst_drop",      32'(bus.oDROP_COUNT), 32'd0);
      check("rst_count",     32'(bus.oBOX_COUNT),  32'd0);
      check("rst_box_hst",   32'(bus.oBOX_HST),    32'd0);
      iRESET = 1'b1;
      tick();
      check("idle_hit_ready", 32'(bus.oHIT_READY), 32'd0);

      // Basic three-line box with column jitter.
      frame_start();
      check("collect_hit_ready", 32'(bus.oHIT_READY), 32'd1);
      send_hit(10, 100, 130);
      send_hit(11, 101, 131);
      send_hit(12, 99, 129);
      run_flush(0);
      check("t1_nbox", 32'(nbox), 32'd1);
      expect_box("t1", 0, 99, 131, 10, 12, 3);
      check("t1_count", 32'(done_cnt), 32'd1);
      check("t1_drop", 32'(bus.oDROP_COUNT), 32'd0);
      tick();
      check("t1_done_pulse", 32'(bus.oDONE), 32'd0);
      check("t1_idle_ready", 32'(bus.oHIT_READY), 32'd0);

      // HSTART deviation just beyond tolerance: two single-line slots.
      frame_start();
      send_hit(10, 100, 130);
      send_hit(11, 105, 130);
      run_flush(0);
      check("t2_nbox", 32'(nbox), 32'd0);
      check("t2_count", 32'(done_cnt), 32'd0);

      // Gap of 4 lines ages the first slot into KEPT.
      frame_start();
      send_hit(20, 50, 80);
      send_hit(21, 50, 80);
      send_hit(22, 50, 80);
      send_hit(26, 50, 80);
      run_flush(0);
      check("t3_nbox", 32'(nbox), 32'd1);
      expect_box("t3", 0, 50, 80, 20, 22, 3);
      check("t3_count", 32'(done_cnt), 32'd1);

      // Same-line hits exhaust the slots; the fourth is dropped.
      frame_start();
      send_hit(5, 10, 20);
      send_hit(5, 100, 120);
      send_hit(5, 300, 320);
      send_hit(5, 500, 520);
      check("t4_drop", 32'(bus.oDROP_COUNT), 32'd1);
      run_flush(0);
      check("t4_nbox", 32'(nbox), 32'd0);
      check("t4_count", 32'(done_cnt), 32'd0);

      // Three boxes with a stalled consumer; slot order must be kept.
      frame_start();
      check("t5_drop_clr", 32'(bus.oDROP_COUNT), 32'd0);
      for (int v = 30; v <= 32; v++) begin
         send_hit(v, 10, 20);
         send_hit(v, 200, 220);
         send_hit(v, 400, 420);
      end
      run_flush(5);
      check("t5_nbox", 32'(nbox), 32'd3);
      expect_box("t5a", 0, 10, 20, 30, 32, 3);
      expect_box("t5b", 1, 200, 220, 30, 32, 3);
      expect_box("t5c", 2, 400, 420, 30, 32, 3);
      check("t5_count", 32'(done_cnt), 32'd3);

      // Tolerance and gap limits exactly at their bounds still match.
      frame_start();
      send_hit(40, 100, 130);
      send_hit(43, 104, 134);
      send_hit(46, 96, 130);
      run_flush(0);
      check("t6_nbox", 32'(nbox), 32'd1);
      expect_box("t6", 0, 96, 134, 40, 46, 3);

      // Asynchronous reset in the middle of a flush.
      frame_start();
      send_hit(60, 10, 20);
      send_hit(61, 10, 20);
      send_hit(62, 10, 20);
      bus.iBOX_READY = 1'b0;
      bus.iFRAME_END = 1'b1;
      tick();
      bus.iFRAME_END = 1'b0;
      wait_valid("t7_valid_before_rst");
      #2 iRESET = 1'b0;
      #1;
      check("t7_rst_valid", 32'(bus.oBOX_VALID), 32'd0);
      check("t7_rst_hst",   32'(bus.oBOX_HST),   32'd0);
      check("t7_rst_ready", 32'(bus.oHIT_READY), 32'd0);
      @(posedge iCLK);
      #1 iRESET = 1'b1;
      tick();
      tick();
      check("t7_post_ready", 32'(bus.oHIT_READY), 32'd0);
      check("t7_post_done",  32'(bus.oDONE),      32'd0);

      // Frame start aborts a flush with no done pulse and frees every slot.
      frame_start();
      send_hit(70, 10, 20);
      send_hit(71, 10, 20);
      send_hit(72, 10, 20);
      bus.iBOX_READY = 1'b0;
      bus.iFRAME_END = 1'b1;
      tick();
      bus.iFRAME_END = 1'b0;
      wait_valid("t8_valid_before_abort");
      frame_start();
      check("t8_abort_valid", 32'(bus.oBOX_VALID), 32'd0);
      check("t8_abort_ready", 32'(bus.oHIT_READY), 32'd1);
      done_any = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (bus.oDONE) done_any = 1'b1;
         tick();
      end
      check("t8_no_done", 32'(done_any), 32'd0);
      run_flush(0);
      check("t8_nbox", 32'(nbox), 32'd0);
      check("t8_count", 32'(done_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
